uart_tx_byte_serializer: RTL and testbench
==========================================

// Module: uart_tx_byte_serializer
// PURPOSE
//   Downstream UART transmit stage for the 8-bit TX message memory.
//   Generates the rising-edge byte-request strobe that steps the message memory, then samples the returned byte.
//   Sends each sampled byte as an 8N1/8N2 frame on o_txd, LSB first.
//   Idle code bytes (0xFF) are dropped, never transmitted.
// PARAMETERS
//   CLK_HZ      50_000_000  system clock frequency (Hz)
//   BAUD        9600        line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide); must be >= 2 (elaboration error otherwise)
//   STOP_BITS   1           1 or 2 stop bits; any other value is an elaboration error
//   REQ_WIDTH   4           clk cycles o_byte_req is held high (>= 1)
//   SETTLE_CYC  4           clk cycles between o_byte_req falling and i_data sampling (>= 1)
//   IDLE_CODE   8'hFF       byte value meaning "no data"
//   SKIP_IDLE   1           1: IDLE_CODE bytes are dropped, no frame sent; 0: transmitted like any other byte
// PORTS
//   clk           in   1   system clock, rising edge
//   reset         in   1   reset, asynchronous, active-low
//   i_enable      in   1   level; allows new byte requests
//   i_data        in   8   byte from the message memory; stable SETTLE_CYC cycles after o_byte_req falls
//   o_byte_req    out  1   registered request pulse; its rising edge advances the upstream counter
//   o_txd         out  1   serial line, idle high
//   o_busy        out  1   high in every state except IDLE
//   o_byte_done   out  1   1-cycle pulse at the end of the last stop-bit cycle
//   o_frame_count out  16  frames completed since reset; wraps 16'hFFFF -> 0
// BEHAVIOUR
//   Reset (async, any state): o_txd=1, o_byte_req=0, o_busy=0, o_byte_done=0, o_frame_count=0, FSM=IDLE.
//     A frame in progress is abandoned immediately. Line returns high with no stop bit.
//   FSM: IDLE -> REQ -> WAIT -> START -> DATA -> STOP -> IDLE. All outputs are registered.
//   IDLE: o_txd=1. If i_enable=1 at a clk edge, enter REQ on the next cycle.
//   REQ: o_byte_req=1 for exactly REQ_WIDTH cycles, then WAIT.
//   WAIT: o_byte_req=0 for SETTLE_CYC cycles; i_data is captured into an 8-bit shift register on the last WAIT cycle.
//     If SKIP_IDLE=1 and the captured byte == IDLE_CODE: return to IDLE. No frame, no o_byte_done, count unchanged.
//     Otherwise enter START.
//   START: o_txd=0 for CLKS_PER_BIT cycles.
//   DATA: 8 bits, bit0 first, each held CLKS_PER_BIT cycles; shift right once per bit.
//     Bit index counter is 3 bits and leaves DATA after index 7.
//   STOP: o_txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
//     On the final STOP cycle: o_byte_done=1 and o_frame_count+1 (both registered). Next cycle: IDLE.
//   Baud counter: reloads at every state entry and counts 0..CLKS_PER_BIT-1, so there is no drift across bits.
//   i_enable falling mid-request or mid-frame: the current request and frame complete normally. No new REQ is issued.
//   i_enable held high: back-to-back operation. IDLE lasts exactly 1 cycle between frames.
//   Frame period = 1 + REQ_WIDTH + SETTLE_CYC + (9+STOP_BITS)*CLKS_PER_BIT cycles.
//   i_data changes outside the sample cycle have no effect. The shift register holds the byte until STOP ends.
// TESTING  (CLK_HZ=1000, BAUD=100 -> CLKS_PER_BIT=10; REQ_WIDTH=4, SETTLE_CYC=4, STOP_BITS=1)
//   1 Reset mid-DATA -> o_txd=1 and o_busy=0 within the same cycle; o_frame_count=0; FSM restarts with REQ once reset releases and i_enable=1.
//   2 i_enable=1, model returns 8'h63 -> o_txd = 0,1,1,0,0,0,1,1,0,1, each held 10 cycles; o_byte_done pulses once; count=1; frame period 109 cycles.
//   3 Model returns 8'hFF, SKIP_IDLE=1 -> no low level on o_txd, count unchanged, next o_byte_req rises 9 cycles after the previous one.
//   4 Upstream message model (35 bytes ending 8'h0A, then 8'hFF) -> exactly 35 frames decoded by a bench UART receiver, matching in order; count=35.
//   5 i_enable dropped at bit 3 of a frame -> frame completes with a correct stop bit; o_byte_req stays 0 afterwards; o_busy falls the cycle after o_byte_done.
//   6 Preload o_frame_count to 16'hFFFF via force -> after next frame, count=0.
//     STOP_BITS=2: stop level lasts 20 cycles.

Source files
------------

// File: rtl/uart_tx_byte_serializer_if.sv
// uart_tx_byte_serializer_if: byte-request handshake and serial line between message memory, serializer and observers
`timescale 1ns/1ps
interface uart_tx_byte_serializer_if;
    logic        i_enable;
    logic [7:0]  i_data;
    logic        o_byte_req;
    logic        o_txd;
    logic        o_busy;
    logic        o_byte_done;
    logic [15:0] o_frame_count;
    modport master (
        output i_enable, i_data,
        input  o_byte_req, o_txd, o_busy, o_byte_done, o_frame_count
    );
    modport slave (
        input  i_enable, i_data,
        output o_byte_req, o_txd, o_busy, o_byte_done, o_frame_count
    );
endinterface

// File: rtl/uart_tx_byte_serializer.sv
// uart_tx_byte_serializer: requests bytes from the TX message memory and sends them as 8N1/8N2 UART frames
`timescale 1ns/1ps
module uart_tx_byte_serializer #(
    parameter int         CLK_HZ     = 50_000_000,
    parameter int         BAUD       = 9600,
    parameter int         STOP_BITS  = 1,
    parameter int         REQ_WIDTH  = 4,
    parameter int         SETTLE_CYC = 4,
    parameter logic [7:0] IDLE_CODE  = 8'hFF,
    parameter bit         SKIP_IDLE  = 1'b1
) (
    input logic                      clk,
    input logic                      reset,
    uart_tx_byte_serializer_if.slave bus
);
    localparam int CPB      = CLK_HZ / BAUD;
    localparam int STOP_LEN = STOP_BITS * CPB;
    localparam int MAX_A    = (REQ_WIDTH > SETTLE_CYC) ? REQ_WIDTH : SETTLE_CYC;
    localparam int MAX_LEN  = (MAX_A > STOP_LEN) ? MAX_A : STOP_LEN;
    localparam int CW       = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] REQ_LAST  = CW'(REQ_WIDTH - 1);
    localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);

    if (CPB < 2) begin : g_bad_baud
        $error("CLK_HZ/BAUD must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (REQ_WIDTH < 1 || SETTLE_CYC < 1) begin : g_bad_len
        $error("REQ_WIDTH and SETTLE_CYC must be at least 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          last;

    // Outputs are derived from the next state so they change on the same edge as the state.
    always_comb begin
        last = cnt_q == (state_q == S_REQ  ? REQ_LAST :
                         state_q == S_WAIT ? SET_LAST :
                         state_q == S_STOP ? STOP_LAST : BIT_LAST);
        state_d = state_q;
        bit_d = bit_q;
        sh_d = sh_q;
        cnt_d = (last || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_IDLE:  state_d = bus.i_enable ? S_REQ : S_IDLE;
            S_REQ:   state_d = last ? S_WAIT : S_REQ;
            S_WAIT: if (last) begin
                sh_d = bus.i_data;
                state_d = (SKIP_IDLE && bus.i_data == IDLE_CODE) ? S_IDLE : S_START;
            end
            S_START: if (last) begin
                state_d = S_DATA;
                bit_d = '0;
            end
            S_DATA: if (last) begin
                sh_d = sh_q >> 1;
                bit_d = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
            end
            S_STOP:  state_d = last ? S_IDLE : S_STOP;
            default: state_d = S_IDLE;
        endcase
        txd_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[0] : 1'b1;
        req_d = state_d == S_REQ;
        busy_d = state_d != S_IDLE;
        done_d = state_d == S_STOP && cnt_d == STOP_LAST;
        frame_count_d = frame_count_q + 16'(done_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q <= '0;
            txd_q <= 1'b1;
            req_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            txd_q <= txd_d;
            req_q <= req_d;
            busy_q <= busy_d;
            done_q <= done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign bus.o_txd = txd_q;
    assign bus.o_byte_req = req_q;
    assign bus.o_busy = busy_q;
    assign bus.o_byte_done = done_q;
    assign bus.o_frame_count = frame_count_q;
endmodule

// File: tb/tb_uart_tx_byte_serializer.sv
// tb_uart_tx_byte_serializer: random-stimulus bench with a message-memory model and a serial-line receiver
`timescale 1ns/1ps
module tb_uart_tx_byte_serializer;
    localparam int CPB  = 10;
    localparam int LOGN = 20000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rst_events = 0;
    int rx_bad = 0;
    int mem_idx = 0;
    int exp_count = 0;
    logic req_prev = 1'b0;
    bit txd_log [LOGN];
    bit busy_log [LOGN];
    bit done_log [LOGN];
    int req_rise [$];
    logic [7:0] mem [$];
    logic [7:0] rx_q [$];

    uart_tx_byte_serializer_if bus ();
    uart_tx_byte_serializer_if bus2 ();

    uart_tx_byte_serializer #(.CLK_HZ(1000), .BAUD(100), .STOP_BITS(1), .REQ_WIDTH(4), .SETTLE_CYC(4),
                              .IDLE_CODE(8'hFF), .SKIP_IDLE(1'b1))
        dut (.clk(clk), .reset(reset), .bus(bus));
    uart_tx_byte_serializer #(.CLK_HZ(1000), .BAUD(100), .STOP_BITS(2), .REQ_WIDTH(4), .SETTLE_CYC(4),
                              .IDLE_CODE(8'hFF), .SKIP_IDLE(1'b1))
        u2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge reset) rst_events++;

    // Upstream message memory: each request rising edge presents the next byte, 0xFF once exhausted.
    always @(posedge bus.o_byte_req) begin
        bus.i_data = (mem_idx < mem.size()) ? mem[mem_idx] : 8'hFF;
        mem_idx++;
    end

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            txd_log[cyc] = bus.o_txd;
            busy_log[cyc] = bus.o_busy;
            done_log[cyc] = bus.o_byte_done;
        end
        if (bus.o_byte_req && !req_prev) req_rise.push_back(cyc);
        if (bus.o_byte_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        req_prev = bus.o_byte_req;
    end

    // Line receiver: mid-bit sampling; frames with a bad stop bit or an intervening reset are counted bad.
    initial begin : rx_proc
        logic [7:0] b;
        bit ok;
        int ev;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus.o_txd === 1'b0) begin
                ev = rst_events;
                repeat (CPB / 2) @(negedge clk);
                ok = bus.o_txd === 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = bus.o_txd;
                end
                repeat (CPB) @(negedge clk);
                ok = ok && bus.o_txd === 1'b1 && ev == rst_events && reset === 1'b1;
                if (ok) rx_q.push_back(b);
                else rx_bad++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        ok = done_cnt >= target;
    endtask

    task automatic wait_rise(input int target, input int budget, output bit ok);
        int n = 0;
        while (req_rise.size() < target && n < budget) begin
            tick();
            n++;
        end
        ok = req_rise.size() >= target;
    endtask

    task automatic test_reset();
        int r;
        bit ok;
        bus.i_enable = 1'b0;
        bus2.i_enable = 1'b0;
        bus2.i_data = 8'h00;
        reset = 1'b0;
        repeat (3) tick();
        checks += 5;
        if (bus.o_txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", bus.o_txd); end
        if (bus.o_byte_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.o_byte_req); end
        if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        if (bus.o_byte_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.o_byte_done); end
        if (bus.o_frame_count !== 16'h0) begin fails++; $display("FAIL reset_count: got %h want 0", bus.o_frame_count); end
        reset = 1'b1;
        mem = {8'h00};
        mem_idx = 0;
        tick();
        bus.i_enable = 1'b1;
        wait_rise(1, 20, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL reset_first_req: got no request want one within 20 cycles"); end
        r = ok ? req_rise[0] : cyc;
        while (cyc < r + 40) tick();
        checks++;
        if (bus.o_txd !== 1'b0) begin fails++; $display("FAIL mid_data_low: got %b want 0", bus.o_txd); end
        reset = 1'b0;
        #1;
        checks += 3;
        if (bus.o_txd !== 1'b1) begin fails++; $display("FAIL async_txd: got %b want 1", bus.o_txd); end
        if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL async_busy: got %b want 0", bus.o_busy); end
        if (bus.o_frame_count !== 16'h0) begin fails++; $display("FAIL async_count: got %h want 0", bus.o_frame_count); end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.o_byte_req !== 1'b1) begin fails++; $display("FAIL restart_req: got %b want 1", bus.o_byte_req); end
        bus.i_enable = 1'b0;
        repeat (150) tick();
        checks++;
        if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_settle_busy: got %b want 0", bus.o_busy); end
        rx_q.delete();
        rx_bad = 0;
        exp_count = 0;
    endtask

    task automatic test_single_byte();
        int n0, d0, r1, r2, bad, dones;
        bit ok;
        logic [9:0] frame;
        mem = {8'h63, 8'h5A};
        mem_idx = 0;
        n0 = req_rise.size();
        d0 = done_cnt;
        bus.i_enable = 1'b1;
        wait_done(d0 + 2, 400, ok);
        bus.i_enable = 1'b0;
        checks++;
        if (!ok) begin fails++; $display("FAIL single_timeout: got %0d frames want 2", done_cnt - d0); end
        r1 = req_rise[n0];
        r2 = req_rise[n0 + 1];
        checks++;
        if (r2 - r1 != 109) begin fails++; $display("FAIL single_period: got %0d want 109", r2 - r1); end
        frame = {1'b1, 8'h63, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int j = 0; j < CPB; j++) if (txd_log[r1 + 8 + CPB * k + j] !== frame[k]) bad++;
            checks++;
            if (bad != 0) begin fails++; $display("FAIL single_bit%0d: got %0d wrong cycles want 0 (level %b)", k, bad, frame[k]); end
        end
        dones = 0;
        for (int c = r1; c < r1 + 109; c++) dones += int'(done_log[c]);
        checks += 3;
        if (dones != 1) begin fails++; $display("FAIL single_done_pulses: got %0d want 1", dones); end
        if (done_log[r1 + 107] !== 1'b1) begin fails++; $display("FAIL single_done_pos: got %b want 1", done_log[r1 + 107]); end
        if (busy_log[r1 + 108] !== 1'b0) begin fails++; $display("FAIL single_idle_gap: got %b want 0", busy_log[r1 + 108]); end
        tick();
        exp_count += 2;
        checks += 2;
        if (bus.o_frame_count !== 16'(exp_count)) begin fails++; $display("FAIL single_count: got %0d want %0d", bus.o_frame_count, exp_count); end
        if (rx_q.size() != 2) begin fails++; $display("FAIL single_rx_len: got %0d want 2", rx_q.size()); end
        else begin
            checks += 2;
            if (rx_q[0] !== 8'h63) begin fails++; $display("FAIL single_rx0: got %h want 63", rx_q[0]); end
            if (rx_q[1] !== 8'h5A) begin fails++; $display("FAIL single_rx1: got %h want 5a", rx_q[1]); end
        end
        rx_q.delete();
    endtask

    task automatic test_skip_idle();
        int n0, d0, r1, r2, lows;
        bit ok;
        mem = {8'hFF, 8'h11};
        mem_idx = 0;
        n0 = req_rise.size();
        d0 = done_cnt;
        bus.i_enable = 1'b1;
        wait_done(d0 + 1, 300, ok);
        bus.i_enable = 1'b0;
        checks++;
        if (!ok) begin fails++; $display("FAIL skip_timeout: got no frame want 1"); end
        r1 = req_rise[n0];
        r2 = req_rise[n0 + 1];
        lows = 0;
        for (int c = r1; c < r2 + 8; c++) if (txd_log[c] !== 1'b1) lows++;
        tick();
        exp_count++;
        checks += 5;
        if (r2 - r1 != 9) begin fails++; $display("FAIL skip_req_spacing: got %0d want 9", r2 - r1); end
        if (lows != 0) begin fails++; $display("FAIL skip_line_low: got %0d low cycles want 0", lows); end
        if (busy_log[r1 + 8] !== 1'b0) begin fails++; $display("FAIL skip_idle: got %b want 0", busy_log[r1 + 8]); end
        if (bus.o_frame_count !== 16'(exp_count)) begin fails++; $display("FAIL skip_count: got %0d want %0d", bus.o_frame_count, exp_count); end
        if (rx_q.size() != 1 || rx_q[0] !== 8'h11) begin fails++; $display("FAIL skip_rx: got %0d bytes want one byte 11", rx_q.size()); end
        rx_q.delete();
    endtask

    task automatic test_message();
        logic [7:0] exp [$];
        logic [7:0] b;
        int d0;
        bit ok;
        mem.delete();
        while (exp.size() < 35) begin
            if ($urandom_range(0, 7) == 0) mem.push_back(8'hFF);
            else begin
                b = (exp.size() == 34) ? 8'h0A : 8'($urandom_range(0, 254));
                mem.push_back(b);
                exp.push_back(b);
            end
        end
        mem.push_back(8'hFF);
        mem_idx = 0;
        d0 = done_cnt;
        bus.i_enable = 1'b1;
        wait_done(d0 + 35, 6000, ok);
        bus.i_enable = 1'b0;
        repeat (20) tick();
        exp_count += 35;
        checks += 4;
        if (!ok) begin fails++; $display("FAIL msg_timeout: got %0d frames want 35", done_cnt - d0); end
        if (rx_bad != 0) begin fails++; $display("FAIL msg_bad_frames: got %0d want 0", rx_bad); end
        if (bus.o_frame_count !== 16'(exp_count)) begin fails++; $display("FAIL msg_count: got %0d want %0d", bus.o_frame_count, exp_count); end
        if (rx_q.size() != 35) begin fails++; $display("FAIL msg_rx_len: got %0d want 35", rx_q.size()); end
        else begin
            for (int i = 0; i < 35; i++) begin
                checks++;
                if (rx_q[i] !== exp[i]) begin fails++; $display("FAIL msg_byte%0d: got %h want %h", i, rx_q[i], exp[i]); end
            end
        end
        rx_q.delete();
    endtask

    task automatic test_enable_drop();
        logic [7:0] b;
        int n0, d0, r;
        bit ok;
        b = 8'($urandom_range(0, 254));
        mem = {b};
        mem_idx = 0;
        n0 = req_rise.size();
        d0 = done_cnt;
        bus.i_enable = 1'b1;
        wait_rise(n0 + 1, 20, ok);
        r = ok ? req_rise[n0] : cyc;
        while (cyc < r + 48) tick();
        bus.i_enable = 1'b0;
        wait_done(d0 + 1, 200, ok);
        tick();
        exp_count++;
        checks += 4;
        if (!ok) begin fails++; $display("FAIL drop_timeout: got no frame want 1"); end
        if (done_cyc != r + 107) begin fails++; $display("FAIL drop_done_pos: got %0d want %0d", done_cyc - r, 107); end
        if (busy_log[done_cyc] !== 1'b1) begin fails++; $display("FAIL drop_busy_at_done: got %b want 1", busy_log[done_cyc]); end
        if (busy_log[done_cyc + 1] !== 1'b0) begin fails++; $display("FAIL drop_busy_after: got %b want 0", busy_log[done_cyc + 1]); end
        repeat (150) tick();
        checks += 5;
        if (req_rise.size() != n0 + 1) begin fails++; $display("FAIL drop_extra_req: got %0d want %0d", req_rise.size() - n0, 1); end
        if (bus.o_byte_req !== 1'b0) begin fails++; $display("FAIL drop_req_level: got %b want 0", bus.o_byte_req); end
        if (rx_bad != 0) begin fails++; $display("FAIL drop_stop_bit: got %0d bad frames want 0", rx_bad); end
        if (rx_q.size() != 1 || rx_q[0] !== b) begin fails++; $display("FAIL drop_rx: got %0d bytes want one byte %h", rx_q.size(), b); end
        if (bus.o_frame_count !== 16'(exp_count)) begin fails++; $display("FAIL drop_count: got %0d want %0d", bus.o_frame_count, exp_count); end
        rx_q.delete();
    endtask

    task automatic test_count_wrap();
        int d0;
        bit ok;
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        tick();
        checks++;
        if (bus.o_frame_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h want ffff", bus.o_frame_count); end
        mem = {8'($urandom_range(0, 254))};
        mem_idx = 0;
        d0 = done_cnt;
        bus.i_enable = 1'b1;
        wait_done(d0 + 1, 200, ok);
        bus.i_enable = 1'b0;
        tick();
        checks += 2;
        if (!ok) begin fails++; $display("FAIL wrap_timeout: got no frame want 1"); end
        if (bus.o_frame_count !== 16'h0) begin fails++; $display("FAIL wrap_count: got %h want 0", bus.o_frame_count); end
        repeat (20) tick();
        rx_q.delete();
    endtask

    task automatic test_stop2();
        logic [7:0] b;
        logic exp_txd;
        b = 8'($urandom_range(0, 254));
        bus2.i_data = b;
        bus2.i_enable = 1'b1;
        tick();
        bus2.i_enable = 1'b0;
        for (int o = 0; o <= 120; o++) begin
            exp_txd = (o < 8) ? 1'b1 : (o < 18) ? 1'b0 : (o < 98) ? b[(o - 18) / CPB] : 1'b1;
            checks += 4;
            if (bus2.o_txd !== exp_txd) begin fails++; $display("FAIL stop2_txd@%0d: got %b want %b", o, bus2.o_txd, exp_txd); end
            if (bus2.o_byte_done !== (o == 117)) begin fails++; $display("FAIL stop2_done@%0d: got %b want %b", o, bus2.o_byte_done, o == 117); end
            if (bus2.o_byte_req !== (o < 4)) begin fails++; $display("FAIL stop2_req@%0d: got %b want %b", o, bus2.o_byte_req, o < 4); end
            if (bus2.o_busy !== (o <= 117)) begin fails++; $display("FAIL stop2_busy@%0d: got %b want %b", o, bus2.o_busy, o <= 117); end
            tick();
        end
        checks++;
        if (bus2.o_frame_count !== 16'd1) begin fails++; $display("FAIL stop2_count: got %0d want 1", bus2.o_frame_count); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_skip_idle();
        test_message();
        test_enable_drop();
        test_count_wrap();
        test_stop2();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
